// File: rtl/vga_delay_pkg.sv
// Shared defaults and helpers for the VGA pixel-path delay lines.
package vga_delay_pkg;

    localparam int POS_WIDTH_DEF    = 12;
    localparam int POS_CHANNELS_DEF = 2;
    localparam int POS_DEPTH_MAX    = 64;

    // Width needed to count 0..depth inclusive.
    function automatic int clog2_depth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/delay_stage.sv
// One register stage of the delay line: data word plus its valid bit.
// Latency 1 cycle; holds when enable=0, cleared by flush regardless of enable.
module delay_stage #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (flush) begin
            r_q <= '0;
        end else if (enable) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pos_delay_line.sv
// Multi-channel delay line keeping position words aligned with the pixel timing path.
// Latency DEPTH enabled cycles; enable=0 stalls every stage; flush clears contents.
// Optional POS_DELAY_HOLD_LAST_EN: data_out holds the last valid word while valid_out=0.
module pos_delay_line
    import vga_delay_pkg::*;
#(
    parameter int WIDTH    = POS_WIDTH_DEF,
    parameter int CHANNELS = POS_CHANNELS_DEF,
    parameter int DEPTH    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      flush,
    input  logic                      valid_in,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [CHANNELS*WIDTH-1:0] data_out,
    output logic                      valid_out,
    output logic                      primed
);

    localparam int DW = CHANNELS * WIDTH;
    localparam int SW = DW + 1;
    localparam int CW = clog2_depth(DEPTH);

    // Valid bit rides in the MSB of each stage word.
    logic [SW-1:0] w_stage [DEPTH+1];
    logic [DW-1:0] w_last_dat;
    logic          w_last_vld;
    logic [CW-1:0] r_count;

    assign w_stage[0] = {valid_in, data_in};

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        delay_stage #(
            .W(SW)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .enable (enable),
            .flush  (flush),
            .d      (w_stage[k]),
            .q      (w_stage[k+1])
        );
    end

    assign w_last_dat = w_stage[DEPTH][DW-1:0];
    assign w_last_vld = w_stage[DEPTH][DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (enable && (r_count != CW'(DEPTH))) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign primed    = (r_count == CW'(DEPTH));
    assign valid_out = w_last_vld;

`ifdef POS_DELAY_HOLD_LAST_EN
    logic [DW-1:0] r_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (flush) begin
            r_hold <= '0;
        end else if (enable && w_last_vld) begin
            r_hold <= w_last_dat;
        end
    end

    assign data_out = w_last_vld ? w_last_dat : r_hold;
`else
    assign data_out = w_last_dat;
`endif

endmodule

// File: tb/tb_pos_delay_line.sv
// Directed plus randomized checks of pos_delay_line against a queue-based reference.
module tb_pos_delay_line;

    localparam int WIDTH    = 12;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 3;
    localparam int DW       = WIDTH * CHANNELS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          flush;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          primed;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: the pipeline is a FIFO of exactly DEPTH entries.
    logic [DW-1:0] m_dat [$];
    bit            m_vld [$];
    int            m_count;
    logic [DW-1:0] m_hold;

    bit            collect;
    logic [WIDTH-1:0] seen [$];

    pos_delay_line #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .flush     (flush),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_dat = {};
        m_vld = {};
        for (int i = 0; i < DEPTH; i++) begin
            m_dat.push_front('0);
            m_vld.push_front(1'b0);
        end
        m_count = 0;
        m_hold  = '0;
    endtask

    task automatic model_edge(input bit en, input bit fl, input bit vin, input logic [DW-1:0] din);
        logic [DW-1:0] old_d;
        bit            old_v;
        if (fl) begin
            model_clear();
        end else if (en) begin
            old_d = m_dat.pop_back();
            old_v = m_vld.pop_back();
            if (old_v) m_hold = old_d;
            m_dat.push_front(din);
            m_vld.push_front(vin);
            if (m_count < DEPTH) m_count++;
        end
    endtask

    function automatic logic [DW-1:0] exp_data();
`ifdef POS_DELAY_HOLD_LAST_EN
        return m_vld[DEPTH-1] ? m_dat[DEPTH-1] : m_hold;
`else
        return m_dat[DEPTH-1];
`endif
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".data"},   64'(data_out),  64'(exp_data()));
        check({tag, ".valid"},  64'(valid_out), 64'(m_vld[DEPTH-1]));
        check({tag, ".primed"}, 64'(primed),    64'(m_count == DEPTH));
    endtask

    task automatic cycle(input string tag, input bit en, input bit fl, input bit vin,
                         input logic [DW-1:0] din);
        enable   = en;
        flush    = fl;
        valid_in = vin;
        data_in  = din;
        @(posedge clk);
        model_edge(en, fl, vin, din);
        @(negedge clk);
        check_all(tag);
        if (collect && en && !fl && valid_out) seen.push_back(data_out[WIDTH-1:0]);
    endtask

    // Reset is asserted between edges and must clear the outputs before the next edge.
    task automatic mid_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, ".data"},   64'(data_out),  64'h0);
        check({tag, ".valid"},  64'(valid_out), 64'h0);
        check({tag, ".primed"}, 64'(primed),    64'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] xs [3];
        rst_n    = 1'b0;
        enable   = 1'b0;
        flush    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        collect  = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check("reset.data",   64'(data_out),  64'h0);
        check("reset.valid",  64'(valid_out), 64'h0);
        check("reset.primed", 64'(primed),    64'h0);
        rst_n = 1'b1;

        // Latency: sample appears after DEPTH enabled edges, primed with it.
        cycle("lat0", 1, 0, 1, {12'd200, 12'd100});
        cycle("lat1", 1, 0, 0, '0);
        check("lat.primed_early", 64'(primed), 64'h0);
        cycle("lat2", 1, 0, 0, '0);
        check("lat.data_out",  64'(data_out),  64'({12'd200, 12'd100}));
        check("lat.valid_out", 64'(valid_out), 64'h1);
        check("lat.primed",    64'(primed),    64'h1);

        // Stall: 5,6,7 with two stalled cycles between 6 and 7.
        collect = 1'b1;
        cycle("st5", 1, 0, 1, 24'd5);
        cycle("st6", 1, 0, 1, 24'd6);
        cycle("stall_a", 0, 0, 1, 24'd99);
        cycle("stall_b", 0, 0, 0, 24'd98);
        cycle("st7", 1, 0, 1, 24'd7);
        for (int i = 0; i < DEPTH; i++) cycle("st_drain", 1, 0, 0, '0);
        collect = 1'b0;
        xs[0] = 12'd5; xs[1] = 12'd6; xs[2] = 12'd7;
        check("stall.count", 64'(seen.size()), 64'd3);
        for (int i = 0; i < 3 && i < seen.size(); i++)
            check("stall.seq", 64'(seen[i]), 64'(xs[i]));

        // Flush with enable low on a full pipeline.
        for (int i = 0; i < DEPTH; i++) cycle("fl_fill", 1, 0, 1, 24'hABC000 + 24'(i));
        cycle("flush", 0, 1, 1, 24'h555555);
        check("flush.valid",  64'(valid_out), 64'h0);
        check("flush.data",   64'(data_out),  64'h0);
        check("flush.primed", 64'(primed),    64'h0);
        for (int i = 0; i < DEPTH - 1; i++) cycle("fl_refill", 1, 0, 0, 24'h1);
        check("flush.not_primed", 64'(primed), 64'h0);
        cycle("fl_refill_last", 1, 0, 0, 24'h1);
        check("flush.primed_again", 64'(primed), 64'h1);

        // Valid gaps: alternating valid with 0xFFF / 0x001 words.
        for (int i = 0; i < 8; i++)
            cycle("gap", 1, 0, (i % 2) == 0, (i % 2) == 0 ? 24'hFFFFFF : 24'h001001);

        // Hold-last behaviour after a valid word followed by invalid ones.
        cycle("hold_flush", 1, 1, 0, '0);
        cycle("hold_v", 1, 0, 1, {12'h0AB, 12'h0AB});
        cycle("hold_i0", 1, 0, 0, {12'h123, 12'h123});
        cycle("hold_i1", 1, 0, 0, {12'h123, 12'h123});
        check("hold.valid_word", 64'(data_out), 64'({12'h0AB, 12'h0AB}));
        cycle("hold_i2", 1, 0, 0, {12'h123, 12'h123});
        check("hold.valid_low", 64'(valid_out), 64'h0);
`ifdef POS_DELAY_HOLD_LAST_EN
        check("hold.data", 64'(data_out[WIDTH-1:0]), 64'h0AB);
`else
        check("hold.data", 64'(data_out[WIDTH-1:0]), 64'h123);
`endif

        // Reset asserted with a full pipeline.
        for (int i = 0; i < DEPTH; i++) cycle("rst_fill", 1, 0, 1, 24'h777000 + 24'(i));
        mid_reset("midrst");
        check_all("post_rst");

        // Randomized traffic with occasional flush and one mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) mid_reset("rand_rst");
            cycle("rand", $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 5,
                  1'($urandom), 24'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/pos_delay_line.md
# pos_delay_line

Parametrised multi-channel register delay line for the VGA pixel path. It delays CHANNELS words of WIDTH bits (e.g. mouse xpos/ypos, or other per-pixel attributes) by DEPTH clock cycles, so they stay aligned with timing signals that pass through other pipeline stages. Compared with a fixed single-stage register it adds:
- per-sample valid tracking
- a global stall (enable)
- a synchronous flush
- a "primed" status flag

It sits between the position sources and the drawing stages.

## Interface
Parameters:
- WIDTH, 12, bits per channel
- CHANNELS, 2, number of parallel channels packed in the data buses
- DEPTH, 1, delay in cycles; legal range 1..64

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- enable  input  1  1 = pipeline advances; 0 = all stages hold
- flush  input  1  synchronous clear of pipeline contents and fill count
- valid_in  input  1  marks data_in as a valid sample
- data_in  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- data_out  output  CHANNELS*WIDTH  delayed data, same packing as data_in
- valid_out  output  1  valid bit travelling with data_out
- primed  output  1  1 once DEPTH enabled cycles have elapsed since reset or flush

## Operation
- Pipeline structure: DEPTH stages, each holding CHANNELS*WIDTH data bits plus one valid bit. Stage 0 loads data_in/valid_in; stage k loads stage k-1.
- data_out and valid_out are driven by the last stage.
- Priority at each edge: rst_n low > flush > enable > hold.
  - flush=1: all data registers go to 0, all valid bits go to 0, fill count goes to 0. This happens regardless of enable.
  - enable=1, flush=0: every stage shifts.
  - enable=0, flush=0: every register, including the fill count, keeps its value.
- Fill counter: width $clog2(DEPTH+1).
  - Increments on each edge with enable=1 and flush=0.
  - Saturates at DEPTH.
  - primed = (count == DEPTH).
- Valid bits travel with their data only; valid_in=0 does not block the shift.
- Channels are independent bit slices with no arithmetic between them.
- Reset mid-operation: the asynchronous assert immediately clears all stages, the count, and any held value. Deassertion is assumed to be synchronised externally.

## Timing
- Reset values: data_out=0, valid_out=0, primed=0.
- Latency: with enable held at 1, data_out/valid_out at edge n+DEPTH equal data_in/valid_in sampled at edge n.
- Stall cycles (enable=0) add one cycle of latency each; no sample is lost or duplicated.
- primed first rises in the cycle after the DEPTH-th enabled edge.
- Flush on edge n: valid_out=0 and primed=0 from edge n onward. The first post-flush sample emerges DEPTH enabled edges after it enters.
- Simultaneous flush and valid_in=1: the incoming sample is discarded.

## Configuration
- Macro POS_DELAY_HOLD_LAST_EN.
- Defined:
  - An extra CHANNELS*WIDTH hold register captures the last-stage data on each edge where the last-stage valid is 1 and the pipeline advances.
  - data_out = last-stage data when valid_out=1, otherwise the hold register.
  - The hold register resets to 0 and is cleared by flush.
  - Latency is unchanged.
- Undefined: data_out is always the raw last-stage data, whatever valid_out is. No hold register is built.

## Structure
- Package vga_delay_pkg:
  - POS_WIDTH_DEF=12
  - POS_CHANNELS_DEF=2
  - POS_DEPTH_MAX=64
  - function clog2_depth for the counter width
- Sub-module delay_stage: one stage of width WIDTH*CHANNELS+1, with ports clk, rst_n, enable, flush, d, q. It is instantiated DEPTH times in a generate loop.
- The top level contains the fill counter and the optional hold register.

## Test plan
- Reset: assert rst_n=0 mid-stream with the pipeline full → data_out=0, valid_out=0, primed=0 within the same cycle, before the next clk edge.
- Latency: DEPTH=3, enable=1, valid_in=1, feed xpos=100, ypos=200 at edge 0 → data_out = {200,100}, valid_out=1 at edge 3. primed=1 after edge 3.
- Stall: DEPTH=2, feed 5,6,7 with enable=0 for 2 cycles between 6 and 7 → output sequence 5,6,7 with no repeats or gaps; data_out is frozen during the stall.
- Flush: DEPTH=4, full pipeline, flush=1 together with enable=0 → next edge valid_out=0, data_out=0, primed=0. primed returns after 4 enabled edges.
- Valid gaps: alternate valid_in 1/0 with data 0xFFF/0x001, DEPTH=2 → valid_out pattern is identical, delayed 2 edges.
- Hold last (POS_DELAY_HOLD_LAST_EN defined): valid sample 0x0AB followed by invalid 0x123 → data_out stays 0x0AB while valid_out=0. With the macro undefined, data_out shows 0x123.
